// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/ack port bundle
//
// Purpose: groups the instruction-memory request/response signals of the
//          IF stage so the fetch unit and the memory model share one port.
// Signals:
//   imem_req    fetch request, held until imem_ack
//   imem_addr   fetch address, stable while imem_req=1
//   imem_ack    1-cycle response strobe, counts only while imem_req=1
//   imem_rdata  instruction word, valid when imem_ack=1
// Modports:
//   master  fetch unit side (drives req/addr)
//   slave   memory side (drives ack/rdata)
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, imem fetch, 1-entry skid, redirect flush
//
// Purpose: holds the PC, issues word fetches over a req/ack port and feeds
//          {fetch_pc, fetch_instr, fetch_valid} to the IF/ID registers.
//          A 1-entry skid buffer absorbs the response that lands while the
//          output slot is stalled. Redirect flushes everything, including a
//          fetch already in flight (its data is drained and dropped).
// Optional feature: define FETCH_PERF_CNT_EN to add perf_fetch_cnt and
//          perf_stall_cnt outputs.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall                 downstream hold of the output slot
//   redirect, redirect_pc flush and restart at redirect_pc (beats stall)
//   imem                  instruction memory port (master modport)
//   fetch_valid/pc/instr  output slot towards the IF/ID register
//   perf_fetch_cnt        accepted (non-discarded) acks  [FETCH_PERF_CNT_EN]
//   perf_stall_cnt        cycles with fetch_valid=1 and stall=1 [FETCH_PERF_CNT_EN]
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  instr_fetch_unit_if.master  imem,
  output logic                fetch_valid,
  output logic [31:0]         fetch_pc,
  output logic [31:0]         fetch_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        fv_q, fv_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] finstr_q, finstr_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic ack_v;
  logic slot_free;
  logic slot_open;
  logic accepted;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    fv_d         = fv_q;
    fpc_d        = fpc_q;
    finstr_d     = finstr_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    ack_v     = req_q & imem.imem_ack;
    slot_free = fv_q & ~stall;
    slot_open = ~fv_q | slot_free;
    accepted  = 1'b0;

    // Consume: a freed slot refills from the skid, otherwise goes empty.
    if (slot_free) begin
      if (skid_v_q) begin
        fv_d     = 1'b1;
        fpc_d    = skid_pc_q;
        finstr_d = skid_instr_q;
        skid_v_d = 1'b0;
      end else begin
        fv_d = 1'b0;
      end
    end

    if (redirect) begin
      fv_d     = 1'b0;
      skid_v_d = 1'b0;
      pc_d     = redirect_pc;
      // With nothing outstanding (idle, or the in-flight fetch completing
      // right now) the target can be requested immediately; otherwise the
      // old request must be held until its ack and its data thrown away.
      if (ack_v || (state_q == S_IDLE)) begin
        state_d = S_BUSY;
        req_d   = 1'b1;
        addr_d  = redirect_pc;
      end else begin
        state_d = S_DRAIN;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!skid_v_q) begin
            state_d = S_BUSY;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        S_BUSY: begin
          if (ack_v) begin
            accepted = 1'b1;
            pc_d     = pc_q + PC_STEP;
            if (slot_open) begin
              // In BUSY pc_q equals the address in flight, so the
              // back-to-back request goes to the following word.
              fv_d     = 1'b1;
              fpc_d    = addr_q;
              finstr_d = imem.imem_rdata;
              addr_d   = pc_q + PC_STEP;
            end else begin
              skid_v_d     = 1'b1;
              skid_pc_d    = addr_q;
              skid_instr_d = imem.imem_rdata;
              req_d        = 1'b0;
              state_d      = S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (ack_v) begin
            state_d = S_BUSY;
            addr_d  = pc_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= 32'h0;
      fv_q         <= 1'b0;
      fpc_q        <= 32'h0;
      finstr_q     <= 32'h0;
      skid_v_q     <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      fv_q         <= fv_d;
      fpc_q        <= fpc_d;
      finstr_q     <= finstr_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign fetch_valid    = fv_q;
  assign fetch_pc       = fpc_q;
  assign fetch_instr    = finstr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (accepted) perf_fetch_d = perf_fetch_q + 32'd1;
    if (fv_q && stall) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  logic unused_accepted;
  assign unused_accepted = accepted;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total;
  int bad;
  int wait_states;
  int wcnt;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (ifc.master),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after wait_states cycles of a held request.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign ifc.imem_ack   = ifc.imem_req && (wcnt == wait_states);
  assign ifc.imem_rdata = instr_of(ifc.imem_addr);

  always @(posedge clk) begin
    if (!ifc.imem_req || ifc.imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (ifc.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", ifc.imem_req); end
    total++; if (ifc.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", ifc.imem_addr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
    total++; if (fetch_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=00000000", fetch_pc); end
    total++; if (fetch_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=00000000", fetch_instr); end
  endtask

  // Ends with fetch_pc=20 in the slot and a request at 24 being acked.
  task automatic test_streaming();
    rst_n = 1'b1;
    step();
    total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin bad++; $display("FAIL stream_first_req got=%b/%h exp=1/00000000", ifc.imem_req, ifc.imem_addr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got=%b exp=0", fetch_valid); end
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || fetch_instr !== instr_of(32'h0)) begin bad++; $display("FAIL stream_out0 got=%b/%h/%h exp=1/00000000/%h", fetch_valid, fetch_pc, fetch_instr, instr_of(32'h0)); end
    total++; if (ifc.imem_addr !== 32'h4) begin bad++; $display("FAIL stream_addr1 got=%h exp=00000004", ifc.imem_addr); end
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (ifc.imem_addr !== 32'(4 * (k + 1)) || ifc.imem_req !== 1'b1) begin bad++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, ifc.imem_addr, 32'(4 * (k + 1))); end
      total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'(4 * k) || fetch_instr !== instr_of(32'(4 * k))) begin bad++; $display("FAIL stream_out k=%0d got=%b/%h/%h exp=1/%h", k, fetch_valid, fetch_pc, fetch_instr, 32'(4 * k)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd20 || fetch_instr !== instr_of(32'd20)) begin bad++; $display("FAIL stall_frozen k=%0d got=%b/%h/%h exp=1/00000014", k, fetch_valid, fetch_pc, fetch_instr); end
      total++; if (ifc.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req k=%0d got=%b exp=0", k, ifc.imem_req); end
    end
    stall = 1'b0;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd24 || fetch_instr !== instr_of(32'd24)) begin bad++; $display("FAIL stall_skid_out got=%b/%h/%h exp=1/00000018", fetch_valid, fetch_pc, fetch_instr); end
    step();
    total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'd28) begin bad++; $display("FAIL stall_restart got=%b/%h exp=1/0000001c", ifc.imem_req, ifc.imem_addr); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL stall_bubble got=%b exp=0", fetch_valid); end
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd28 || fetch_instr !== instr_of(32'd28)) begin bad++; $display("FAIL stall_next got=%b/%h/%h exp=1/0000001c", fetch_valid, fetch_pc, fetch_instr); end
  endtask

  task automatic test_redirect_inflight();
    wait_states = 3;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rdi_flush got=%b exp=0", fetch_valid); end
    total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'd32) begin bad++; $display("FAIL rdi_hold0 got=%b/%h exp=1/00000020", ifc.imem_req, ifc.imem_addr); end
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (ifc.imem_addr !== 32'd32 || fetch_valid !== 1'b0) begin bad++; $display("FAIL rdi_hold k=%0d got=%h/%b exp=00000020/0", k, ifc.imem_addr, fetch_valid); end
    end
    step();
    total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h100 || fetch_valid !== 1'b0) begin bad++; $display("FAIL rdi_new_req got=%b/%h/%b exp=1/00000100/0", ifc.imem_req, ifc.imem_addr, fetch_valid); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (ifc.imem_addr !== 32'h100 || fetch_valid !== 1'b0) begin bad++; $display("FAIL rdi_wait k=%0d got=%h/%b exp=00000100/0", k, ifc.imem_addr, fetch_valid); end
    end
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100 || fetch_instr !== instr_of(32'h100)) begin bad++; $display("FAIL rdi_target got=%b/%h/%h exp=1/00000100", fetch_valid, fetch_pc, fetch_instr); end
    total++; if (ifc.imem_addr !== 32'h104) begin bad++; $display("FAIL rdi_next_addr got=%h exp=00000104", ifc.imem_addr); end
  endtask

  task automatic test_redirect_ack();
    wait_states = 0;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h200 || fetch_valid !== 1'b0) begin bad++; $display("FAIL rda_req got=%b/%h/%b exp=1/00000200/0", ifc.imem_req, ifc.imem_addr, fetch_valid); end
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h200 || fetch_instr !== instr_of(32'h200)) begin bad++; $display("FAIL rda_out got=%b/%h/%h exp=1/00000200", fetch_valid, fetch_pc, fetch_instr); end
  endtask

  task automatic test_redirect_stall_skid();
    stall = 1'b1;
    step();
    total++; if (ifc.imem_req !== 1'b0 || fetch_pc !== 32'h200) begin bad++; $display("FAIL rss_skid_full got=%b/%h exp=0/00000200", ifc.imem_req, fetch_pc); end
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rss_flush got=%b exp=0", fetch_valid); end
    total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h300) begin bad++; $display("FAIL rss_req got=%b/%h exp=1/00000300", ifc.imem_req, ifc.imem_addr); end
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h300 || fetch_instr !== instr_of(32'h300)) begin bad++; $display("FAIL rss_out got=%b/%h/%h exp=1/00000300", fetch_valid, fetch_pc, fetch_instr); end
    stall = 1'b0;
  endtask

  task automatic test_wrap_and_midreset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    total++; if (ifc.imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_req got=%h exp=fffffff8", ifc.imem_addr); end
    step();
    step();
    total++; if (fetch_pc !== 32'hFFFF_FFFC || ifc.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_edge got=%h/%h exp=fffffffc/00000000", fetch_pc, ifc.imem_addr); end
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || ifc.imem_addr !== 32'h4) begin bad++; $display("FAIL wrap_zero got=%b/%h/%h exp=1/00000000/00000004", fetch_valid, fetch_pc, ifc.imem_addr); end
    wait_states = 3;
    step();
    total++; if (ifc.imem_req !== 1'b1) begin bad++; $display("FAIL midrst_pending got=%b exp=1", ifc.imem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ifc.imem_req !== 1'b0 || ifc.imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_bus got=%b/%h exp=0/00000000", ifc.imem_req, ifc.imem_addr); end
    total++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h0 || fetch_instr !== 32'h0) begin bad++; $display("FAIL midrst_out got=%b/%h/%h exp=0/0/0", fetch_valid, fetch_pc, fetch_instr); end
    step();
    wait_states = 0;
    rst_n = 1'b1;
    step();
    total++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_restart got=%b/%h exp=1/00000000", ifc.imem_req, ifc.imem_addr); end
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || fetch_instr !== instr_of(32'h0)) begin bad++; $display("FAIL midrst_first got=%b/%h/%h exp=1/00000000", fetch_valid, fetch_pc, fetch_instr); end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    wait_states = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_inflight();
    test_redirect_ack();
    test_redirect_stall_skid();
    test_wrap_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
